// File: rtl/tdc_evt_dma.sv
// TDC event-readout scheduler: captures per-channel timestamps, arbitrates them round-robin
// into a small event FIFO and writes each event as a header/timestamp word pair into an SRAM ring.
module tdc_evt_dma #(
  parameter int g_CHANNEL_COUNT = 2,
  parameter int g_FIFO_DEPTH    = 8,
  parameter int g_RING_AW       = 12
) (
  input  logic                          wb_clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic [31:0]                   base_i,
  input  logic [g_RING_AW-1:0]          rd_ptr_i,
  input  logic                          irq_ack_i,
  input  logic [g_CHANNEL_COUNT-1:0]    detect_i,
  input  logic [32*g_CHANNEL_COUNT-1:0] ts_i,
  output logic [g_RING_AW-1:0]          wr_ptr_o,
  output logic [15:0]                   drop_cnt_o,
  output logic                          irq_o,
  output logic [31:0]                   wb_adr_o,
  output logic [31:0]                   wb_dat_o,
  output logic [3:0]                    wb_sel_o,
  output logic [2:0]                    wb_cti_o,
  output logic                          wb_we_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  input  logic                          wb_ack_i
);

  localparam int NCH = g_CHANNEL_COUNT;
  localparam int PW  = $clog2(g_FIFO_DEPTH);
  localparam int EW  = 59;
  localparam logic [PW:0] FDEPTH = (PW+1)'(g_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1} state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Word offset is added to base[31:2] only, so the sum wraps modulo 2^30 words.
  function automatic logic [31:0] word_addr(input logic [29:0] base_w,
                                            input logic [g_RING_AW-1:0] off);
    logic [29:0] w;
    w = base_w + 30'(off);
    return {w, 2'b00};
  endfunction

  logic [NCH-1:0]       pend_q, pend_d, det_en, gnt_oh, drop_v;
  logic [31:0]          hold_q [NCH];
  logic [3:0]           drop_n;
  logic [15:0]          drop_q, drop_d;

  logic [2:0]           arb_ptr_q, arb_ptr_d, gnt_idx;
  logic                 gnt_vld;
  logic [31:0]          gnt_ts;
  logic [23:0]          seq_q, seq_d;

  logic [EW-1:0]        mem [g_FIFO_DEPTH];
  logic [PW-1:0]        fwp_q, frp_q;
  logic [PW:0]          fcnt_q, fcnt_d;
  logic                 fifo_full, fifo_empty;

  state_e               state_q, state_d;
  logic [EW-1:0]        ent_q;
  logic                 load, retire, ring_room;
  logic [g_RING_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic                 irq_q, irq_d, cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0]          adr_q, adr_d, dat_q, dat_d;
  logic                 unused_base;

  assign unused_base = ^base_i[1:0];

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(arb_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      for (int j = 0; j < NCH; j++) begin
        if (!gnt_vld && pend_q[j] && (idx == j)) begin
          gnt_vld = 1'b1;
          gnt_idx = 3'(j);
        end
      end
    end
    if (fifo_full) gnt_vld = 1'b0;

    gnt_oh = '0;
    gnt_ts = '0;
    for (int j = 0; j < NCH; j++) begin
      gnt_oh[j] = gnt_vld && (gnt_idx == 3'(j));
      if (gnt_oh[j]) gnt_ts = hold_q[j];
    end

    arb_ptr_d = arb_ptr_q;
    seq_d     = seq_q;
    if (gnt_vld) begin
      arb_ptr_d = (int'(gnt_idx) + 1 >= NCH) ? 3'd0 : gnt_idx + 3'd1;
      seq_d     = seq_q + 24'd1;
    end
  end

  // A channel granted this cycle frees its hold slot, so a same-cycle detect is kept, not dropped.
  always_comb begin
    det_en = detect_i & {NCH{en_i}};
    pend_d = (pend_q & ~gnt_oh) | det_en;
    drop_v = det_en & pend_q & ~gnt_oh;
    drop_n = '0;
    for (int j = 0; j < NCH; j++) drop_n = drop_n + 4'(drop_v[j]);
    drop_d = sat_add16(drop_q, drop_n);
  end

  always_comb begin
    fifo_full  = (fcnt_q == FDEPTH);
    fifo_empty = (fcnt_q == '0);
    case ({gnt_vld, retire})
      2'b10:   fcnt_d = fcnt_q + (PW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (PW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q    <= '0;
      drop_q    <= '0;
      arb_ptr_q <= '0;
      seq_q     <= '0;
      fwp_q     <= '0;
      frp_q     <= '0;
      fcnt_q    <= '0;
    end else begin
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      arb_ptr_q <= arb_ptr_d;
      seq_q     <= seq_d;
      fcnt_q    <= fcnt_d;
      if (gnt_vld) fwp_q <= fwp_q + PW'(1);
      if (retire)  frp_q <= frp_q + PW'(1);
    end
  end

  // The head entry stays counted in the FIFO until its second word is acknowledged.
  always_ff @(posedge wb_clk_i) begin
    for (int j = 0; j < NCH; j++) begin
      if (det_en[j] && (!pend_q[j] || gnt_oh[j])) hold_q[j] <= ts_i[32*j +: 32];
    end
    if (gnt_vld) mem[fwp_q] <= {gnt_idx, seq_q, gnt_ts};
    if (load)    ent_q      <= mem[frp_q];
  end

  assign ring_room = ((wr_ptr_q + g_RING_AW'(2)) != rd_ptr_i);

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty && ring_room) state_d = S_W0;
      S_W0:    if (cyc_q && wb_ack_i)        state_d = S_W1;
      S_W1:    if (wb_ack_i)                 state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    wr_ptr_d = wr_ptr_q;
    irq_d    = irq_ack_i ? 1'b0 : irq_q;
    load     = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: load = (state_d == S_W0);
      S_W0: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = word_addr(base_i[31:2], wr_ptr_q);
          dat_d = {1'b1, 4'b0000, ent_q[58:32]};
        end else if (wb_ack_i) begin
          adr_d = word_addr(base_i[31:2], wr_ptr_q + g_RING_AW'(1));
          dat_d = ent_q[31:0];
        end
      end
      S_W1: begin
        if (wb_ack_i) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          wr_ptr_d = wr_ptr_q + g_RING_AW'(2);
          irq_d    = 1'b1;
          retire   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      irq_q    <= irq_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign drop_cnt_o = drop_q;
  assign irq_o      = irq_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = 4'hF;
  assign wb_cti_o   = 3'b000;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;

endmodule
